mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

Memory-stage data-memory access controller for the MIPS32 core, directly downstream of the EX/MEM pipeline register. It consumes the M-stage load/store controls, physical address and store data. It drives an SRAM-like request/response data bus with byte-lane generation, detects misaligned accesses, and stalls the pipeline until the transaction completes. It returns sign- or zero-extended load data toward MEM/WB.

## Interface
- Parameters: none. Width encodings and state codes come from the shared package.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- MemToRegM  in  1  instruction in M is a load
- MemWriteM  in  1  instruction in M is a store
- MemWidthM  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
- LoadUnsignedM  in  1  zero-extend load result (1) / sign-extend (0)
- PhyAddrM  in  32  physical byte address
- WriteDataM  in  32  store data, right-aligned
- ExceptionTypeM  in  32  nonzero = earlier exception pending; suppresses access
- AdvanceM  in  1  MEM/WB register enable this cycle (instruction leaves M)
- data_req  out  1  bus request
- data_wr  out  1  1 = write
- data_size  out  2  0 byte, 1 half, 2 word
- data_addr  out  32  = PhyAddrM
- data_wstrb  out  4  byte-lane write strobes
- data_wdata  out  32  lane-replicated store data
- data_addr_ok  in  1  request accepted this cycle
- data_data_ok  in  1  read data valid / write complete this cycle
- data_rdata  in  32  read data
- ReadDataM  out  32  extended load result
- StallM  out  1  hold pipeline (EX/MEM en low, MEM/WB must not advance)
- AdelM  out  1  load address error
- AdesM  out  1  store address error

## Operation
- access = (MemToRegM | MemWriteM) & (ExceptionTypeM == 0) & !misaligned.
- misaligned: half with PhyAddrM[0]=1; word with PhyAddrM[1:0]!=0; byte never. AdelM = MemToRegM & misaligned & (ExceptionTypeM==0); AdesM is the same with MemWriteM. Both are combinational. No request is issued for a misaligned access.
- States:
  - IDLE → REQ when access & !data_addr_ok.
  - IDLE → WAIT when access & data_addr_ok.
  - REQ → WAIT on data_addr_ok.
  - WAIT → DONE on data_data_ok. For a load, data_rdata is captured into rdata_q.
  - DONE → IDLE on AdvanceM.
- data_req = (state==IDLE & access) | state==REQ. data_wr, data_size, data_wstrb and data_wdata are driven from current M inputs whenever data_req=1. They are held stable, because StallM keeps EX/MEM frozen.
- StallM = access & (state != DONE). In DONE, StallM=0 even if AdvanceM is low (other stall source), and no re-issue occurs.
- Write lanes, little-endian:
  - byte: wstrb = 1<<PhyAddrM[1:0], wdata = {4{WriteDataM[7:0]}}.
  - half: wstrb = PhyAddrM[1] ? 1100 : 0011, wdata = {2{WriteDataM[15:0]}}.
  - word: wstrb = 1111, wdata = WriteDataM.
- Load extract: shifted = rdata_q >> (8*PhyAddrM[1:0]). Byte takes shifted[7:0] and half takes shifted[15:0], each extended per LoadUnsignedM. Word passes rdata_q. ReadDataM is meaningful only in DONE; otherwise it is the extension of the stale rdata_q.
- data_data_ok outside WAIT is ignored. data_addr_ok outside IDLE/REQ is ignored.

## Timing
- Reset: state=IDLE, rdata_q=0. Outputs follow combinationally: data_req=0, StallM=0, ReadDataM=0 for inputs with no access.
- Fastest access (addr_ok in cycle 0, data_ok in cycle 1): StallM is high in cycles 0–1, and DONE with StallM=0 comes in cycle 2. The minimum stall is 2 cycles, for both loads and stores.
- Each extra cycle without addr_ok or data_ok adds one stall cycle.
- addr_ok and data_ok in the same cycle for the same request is illegal on this bus and is not handled.
- Reset asserted mid-transaction returns immediately to IDLE. The outstanding bus transaction is abandoned (the slave shares rst).
- ExceptionTypeM becoming nonzero while in REQ/WAIT does not cancel the transaction; it completes to DONE.
- Back-to-back accesses: DONE→IDLE on AdvanceM. The next instruction's request can assert in the following cycle.

## Structure
- Shared package mips_mem_pkg holds:
  - width codes MEM_BYTE/MEM_HALF/MEM_WORD
  - bus size codes
  - state encoding IDLE/REQ/WAIT/DONE (2 bits)
- Sub-module mem_load_ext is combinational: rdata, addr[1:0], width and unsigned in; extended data out. It is reused by the future uncached/cache path.

## Test plan
- lw at 0x1000, addr_ok cycle 0, data_ok cycle 1 with rdata 0x80FF1234 → StallM high for 2 cycles, then ReadDataM=0x80FF1234, wstrb unused.
- lb at 0x1003 with rdata 0x80FF1234 → ReadDataM=0xFFFFFF80. lbu → 0x00000080. lhu at 0x1002 → 0x000080FF.
- sh at 0x2002 with WriteDataM=0x0000BEEF → data_wr=1, size=1, wstrb=1100, wdata=0xBEEFBEEF. addr_ok delayed 3 cycles → StallM high for 5 cycles.
- lw at 0x1001 → AdelM=1, data_req=0, StallM=0. The same with ExceptionTypeM≠0 → AdelM=0, no request.
- Load completes while AdvanceM is held low for 3 cycles → stays in DONE, single request only, StallM=0, ReadDataM stable.
- rst asserted in WAIT → state IDLE, rdata_q=0. A late data_ok after release is ignored.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared encodings for the M-stage data-memory path: access widths, bus size
// codes, controller states and the alignment rule.
package mips_mem_pkg;

   localparam logic [1:0] MEM_BYTE = 2'b00;
   localparam logic [1:0] MEM_HALF = 2'b01;
   localparam logic [1:0] MEM_WORD = 2'b10;

   localparam logic [1:0] BUS_BYTE = 2'd0;
   localparam logic [1:0] BUS_HALF = 2'd1;
   localparam logic [1:0] BUS_WORD = 2'd2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } mem_state_e;

   // The reserved width code 11 follows the word alignment rule.
   function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] addr);
      logic mis;
      mis = 1'b0;
      case (width)
         MEM_BYTE: mis = 1'b0;
         MEM_HALF: mis = addr[0];
         default:  mis = (addr != 2'b00);
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Load-data extraction: selects the addressed byte/half from a bus word and
// sign- or zero-extends it; words pass through untouched.
module mem_load_ext
   import mips_mem_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  addr,
   input  logic [1:0]  width,
   input  logic        load_unsigned,
   output logic [31:0] ext_data
);

   logic [31:0] shifted_s;

   // Lane shift followed by width-dependent extension
   always_comb begin
      shifted_s = rdata >> {addr, 3'b000};
      ext_data  = rdata;
      case (width)
         MEM_BYTE: begin
            if (load_unsigned) begin
               ext_data = {24'h000000, shifted_s[7:0]};
            end else begin
               ext_data = {{24{shifted_s[7]}}, shifted_s[7:0]};
            end
         end
         MEM_HALF: begin
            if (load_unsigned) begin
               ext_data = {16'h0000, shifted_s[15:0]};
            end else begin
               ext_data = {{16{shifted_s[15]}}, shifted_s[15:0]};
            end
         end
         default: ext_data = rdata;
      endcase
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// M-stage data-memory access controller: issues one SRAM-like bus transaction
// per load/store, stalls the pipeline until it completes, and extends load data.
module mem_access_ctrl
   import mips_mem_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        MemToRegM,
   input  logic        MemWriteM,
   input  logic [1:0]  MemWidthM,
   input  logic        LoadUnsignedM,
   input  logic [31:0] PhyAddrM,
   input  logic [31:0] WriteDataM,
   input  logic [31:0] ExceptionTypeM,
   input  logic        AdvanceM,
   output logic        data_req,
   output logic        data_wr,
   output logic [1:0]  data_size,
   output logic [31:0] data_addr,
   output logic [3:0]  data_wstrb,
   output logic [31:0] data_wdata,
   input  logic        data_addr_ok,
   input  logic        data_data_ok,
   input  logic [31:0] data_rdata,
   output logic [31:0] ReadDataM,
   output logic        StallM,
   output logic        AdelM,
   output logic        AdesM
);

   mem_state_e  state_r;
   mem_state_e  next_state_s;
   logic [31:0] rdata_r;
   logic        misaligned_s;
   logic        no_exc_s;
   logic        access_s;
   logic [3:0]  wstrb_s;

   assign misaligned_s = is_misaligned(MemWidthM, PhyAddrM[1:0]);
   assign no_exc_s     = (ExceptionTypeM == 32'd0);
   assign access_s     = (MemToRegM | MemWriteM) & no_exc_s & ~misaligned_s;
   assign AdelM        = MemToRegM & misaligned_s & no_exc_s;
   assign AdesM        = MemWriteM & misaligned_s & no_exc_s;

   // DONE releases the stall but holds the result until the instruction leaves M
   assign StallM     = access_s & (state_r != DONE);
   assign data_req   = ((state_r == IDLE) & access_s) | (state_r == REQ);
   assign data_wr    = data_req & MemWriteM;
   assign data_addr  = PhyAddrM;
   assign data_wstrb = (data_req & MemWriteM) ? wstrb_s : 4'b0000;

   // Controller state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Load data capture when the read response arrives
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rdata_r <= 32'h00000000;
      end else if ((state_r == WAIT) && data_data_ok && MemToRegM) begin
         rdata_r <= data_rdata;
      end
   end

   // Next-state logic; handshakes outside their own state are ignored
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE: begin
            if (access_s) begin
               next_state_s = data_addr_ok ? WAIT : REQ;
            end else begin
               next_state_s = IDLE;
            end
         end
         REQ: begin
            if (data_addr_ok) begin
               next_state_s = WAIT;
            end else begin
               next_state_s = REQ;
            end
         end
         WAIT: begin
            if (data_data_ok) begin
               next_state_s = DONE;
            end else begin
               next_state_s = WAIT;
            end
         end
         DONE: begin
            if (AdvanceM) begin
               next_state_s = IDLE;
            end else begin
               next_state_s = DONE;
            end
         end
         default: next_state_s = IDLE;
      endcase
   end

   // Little-endian lane replication and byte strobes
   always_comb begin
      data_size  = BUS_WORD;
      wstrb_s    = 4'b1111;
      data_wdata = WriteDataM;
      case (MemWidthM)
         MEM_BYTE: begin
            data_size  = BUS_BYTE;
            wstrb_s    = 4'b0001 << PhyAddrM[1:0];
            data_wdata = {4{WriteDataM[7:0]}};
         end
         MEM_HALF: begin
            data_size  = BUS_HALF;
            wstrb_s    = PhyAddrM[1] ? 4'b1100 : 4'b0011;
            data_wdata = {2{WriteDataM[15:0]}};
         end
         default: begin
            data_size  = BUS_WORD;
            wstrb_s    = 4'b1111;
            data_wdata = WriteDataM;
         end
      endcase
   end

   mem_load_ext u_load_ext (
      .rdata         (rdata_r),
      .addr          (PhyAddrM[1:0]),
      .width         (MemWidthM),
      .load_unsigned (LoadUnsignedM),
      .ext_data      (ReadDataM)
   );

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: a bench-side bus slave with programmable
// handshake delays; expectations are queued at issue and compared at completion.
module tb_mem_access_ctrl;
   import mips_mem_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        MemToRegM, MemWriteM, LoadUnsignedM, AdvanceM;
   logic [1:0]  MemWidthM;
   logic [31:0] PhyAddrM, WriteDataM, ExceptionTypeM;
   logic        data_req, data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr, data_wdata, data_rdata, ReadDataM;
   logic [3:0]  data_wstrb;
   logic        data_addr_ok, data_data_ok;
   logic        StallM, AdelM, AdesM;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        is_load;
      logic [31:0] rd;
      int          stall;
      logic [1:0]  size;
      logic [3:0]  wstrb;
      logic [31:0] wdata;
      logic [31:0] addr;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   mem_access_ctrl dut (
      .clk(clk), .rst(rst),
      .MemToRegM(MemToRegM), .MemWriteM(MemWriteM), .MemWidthM(MemWidthM),
      .LoadUnsignedM(LoadUnsignedM), .PhyAddrM(PhyAddrM), .WriteDataM(WriteDataM),
      .ExceptionTypeM(ExceptionTypeM), .AdvanceM(AdvanceM),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
      .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
      .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
      .ReadDataM(ReadDataM), .StallM(StallM), .AdelM(AdelM), .AdesM(AdesM)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   // Reference load extraction written as explicit byte/half selection
   function automatic logic [31:0] model_load(input logic [31:0] rd, input logic [1:0] a,
                                              input logic [1:0] w, input logic uns);
      logic [7:0]  b;
      logic [15:0] h;
      case (a)
         2'd0:    b = rd[7:0];
         2'd1:    b = rd[15:8];
         2'd2:    b = rd[23:16];
         default: b = rd[31:24];
      endcase
      h = a[1] ? rd[31:16] : rd[15:0];
      if (w == 2'b00) return uns ? {24'h0, b} : {{24{b[7]}}, b};
      if (w == 2'b01) return uns ? {16'h0, h} : {{16{h[15]}}, h};
      return rd;
   endfunction

   task automatic idle_inputs();
      MemToRegM = 1'b0; MemWriteM = 1'b0; MemWidthM = 2'b10; LoadUnsignedM = 1'b0;
      PhyAddrM = 32'h0; WriteDataM = 32'h0; ExceptionTypeM = 32'h0; AdvanceM = 1'b0;
      data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'hDEADBEEF;
   endtask

   // One access: issue, serve the bus with delays, compare at completion,
   // hold in DONE for 'hold' cycles, then advance. Called at a negedge.
   task automatic run_txn(input logic ld, input logic [1:0] w, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                          input int adly, input int ddly, input int hold, input logic [31:0] exp_rd);
      exp_t e;
      exp_t c;
      int   cyc = 0;
      int   acc_cyc = 0;
      int   stall_cnt = 0;
      int   n_acc = 0;
      bit   accepted = 1'b0;
      bit   seen_req = 1'b0;
      bit   done = 1'b0;
      e.is_load = ld; e.rd = exp_rd; e.stall = adly + ddly + 1; e.addr = addr;
      e.size = (w == 2'b00) ? 2'd0 : (w == 2'b01) ? 2'd1 : 2'd2;
      case (w)
         2'b00: begin
            e.wdata = {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
            e.wstrb = (addr[1:0] == 2'd0) ? 4'b0001 : (addr[1:0] == 2'd1) ? 4'b0010 :
                      (addr[1:0] == 2'd2) ? 4'b0100 : 4'b1000;
         end
         2'b01: begin
            e.wdata = {wd[15:0], wd[15:0]};
            e.wstrb = addr[1] ? 4'b1100 : 4'b0011;
         end
         default: begin
            e.wdata = wd;
            e.wstrb = 4'b1111;
         end
      endcase
      sb.push_back(e);
      MemToRegM = ld; MemWriteM = ~ld; MemWidthM = w; LoadUnsignedM = uns;
      PhyAddrM = addr; WriteDataM = wd; ExceptionTypeM = 32'h0; AdvanceM = 1'b0;
      data_rdata = rd;
      while (!done && cyc < 40) begin
         data_addr_ok = (!accepted && cyc >= adly);
         data_data_ok = (accepted && cyc >= acc_cyc + ddly);
         #1;
         if (!StallM) begin
            done = 1'b1;
         end else begin
            stall_cnt++;
            if (data_req && !seen_req) begin
               seen_req = 1'b1;
               c = sb[0];
               check_val("req_wr", {31'h0, data_wr}, {31'h0, ~c.is_load});
               check_val("req_size", {30'h0, data_size}, {30'h0, c.size});
               check_val("req_addr", data_addr, c.addr);
               if (!c.is_load) begin
                  check_val("req_wstrb", {28'h0, data_wstrb}, {28'h0, c.wstrb});
                  check_val("req_wdata", data_wdata, c.wdata);
               end
            end
            if (data_req && data_addr_ok && !accepted) begin
               accepted = 1'b1;
               acc_cyc = cyc;
               n_acc++;
            end
            @(negedge clk);
            cyc++;
         end
      end
      if (!done) check_val("timeout_stall", {31'h0, StallM}, 32'h0);
      c = sb.pop_front();
      check_val("stall_cycles", stall_cnt, c.stall);
      if (c.is_load) check_val("load_data", ReadDataM, c.rd);
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         data_addr_ok = 1'b1;
         data_data_ok = 1'b1;
         data_rdata = ~rd;
         #1;
         if (data_req && data_addr_ok) n_acc++;
         check_val("done_stall", {31'h0, StallM}, 32'h0);
         if (c.is_load) check_val("done_rdata", ReadDataM, c.rd);
      end
      if (hold > 0) check_val("single_req", n_acc, 1);
      @(negedge clk);
      AdvanceM = 1'b1; data_addr_ok = 1'b0; data_data_ok = 1'b0;
      @(negedge clk);
      idle_inputs();
   endtask

   initial begin
      logic        ld, uns;
      logic [1:0]  w;
      logic [31:0] a, wd, rd;
      int          adly, ddly;
      idle_inputs();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check_val("rst_req", {31'h0, data_req}, 32'h0);
      check_val("rst_stall", {31'h0, StallM}, 32'h0);
      check_val("rst_rdata", ReadDataM, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      run_txn(1'b1, 2'b10, 1'b0, 32'h1000, 32'h0, 32'h80FF1234, 0, 1, 0, 32'h80FF1234);
      run_txn(1'b1, 2'b00, 1'b0, 32'h1003, 32'h0, 32'h80FF1234, 0, 1, 0, 32'hFFFFFF80);
      run_txn(1'b1, 2'b00, 1'b1, 32'h1003, 32'h0, 32'h80FF1234, 1, 1, 0, 32'h00000080);
      run_txn(1'b1, 2'b01, 1'b1, 32'h1002, 32'h0, 32'h80FF1234, 0, 2, 0, 32'h000080FF);
      run_txn(1'b0, 2'b01, 1'b0, 32'h2002, 32'h0000BEEF, 32'h0, 3, 1, 0, 32'h0);
      run_txn(1'b0, 2'b00, 1'b0, 32'h2001, 32'h000000A5, 32'h0, 0, 1, 0, 32'h0);
      run_txn(1'b1, 2'b01, 1'b0, 32'h1000, 32'h0, 32'h5A5A8001, 0, 1, 3, 32'hFFFF8001);

      // Misaligned accesses and exception suppression
      MemToRegM = 1'b1; MemWidthM = 2'b10; PhyAddrM = 32'h1001;
      #1;
      check_val("adel", {31'h0, AdelM}, 32'h1);
      check_val("adel_ades", {31'h0, AdesM}, 32'h0);
      check_val("adel_req", {31'h0, data_req}, 32'h0);
      check_val("adel_stall", {31'h0, StallM}, 32'h0);
      ExceptionTypeM = 32'h00000004;
      #1;
      check_val("exc_adel", {31'h0, AdelM}, 32'h0);
      check_val("exc_req", {31'h0, data_req}, 32'h0);
      MemToRegM = 1'b0; MemWriteM = 1'b1; MemWidthM = 2'b01; PhyAddrM = 32'h2001;
      ExceptionTypeM = 32'h0;
      #1;
      check_val("ades", {31'h0, AdesM}, 32'h1);
      check_val("ades_req", {31'h0, data_req}, 32'h0);
      @(negedge clk);
      idle_inputs();

      // Reset in WAIT, then a late data_ok must be ignored
      @(negedge clk);
      MemToRegM = 1'b1; MemWidthM = 2'b10; PhyAddrM = 32'h1000; data_addr_ok = 1'b1;
      @(negedge clk);
      data_addr_ok = 1'b0;
      #1;
      check_val("wait_stall", {31'h0, StallM}, 32'h1);
      check_val("wait_req", {31'h0, data_req}, 32'h0);
      idle_inputs();
      rst = 1'b0;
      #1;
      check_val("rst_wait_rdata", ReadDataM, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      data_data_ok = 1'b1; data_rdata = 32'h12345678;
      @(negedge clk);
      data_data_ok = 1'b0;
      #1;
      check_val("late_ok_req", {31'h0, data_req}, 32'h0);
      check_val("late_ok_rdata", ReadDataM, 32'h0);
      @(negedge clk);
      run_txn(1'b1, 2'b10, 1'b0, 32'h1004, 32'h0, 32'hCAFEF00D, 0, 1, 0, 32'hCAFEF00D);

      // Randomised aligned accesses checked against the reference extraction
      for (int i = 0; i < 10; i++) begin
         ld   = $urandom_range(0, 1);
         w    = $urandom_range(0, 2);
         uns  = $urandom_range(0, 1);
         a    = {20'h00003, 10'($urandom), 2'($urandom)};
         if (w == 2'b01) a[0] = 1'b0;
         if (w == 2'b10) a[1:0] = 2'b00;
         wd   = $urandom;
         rd   = $urandom;
         adly = $urandom_range(0, 2);
         ddly = $urandom_range(1, 3);
         run_txn(ld, w, uns, a, wd, rd, adly, ddly, i % 2, model_load(rd, a[1:0], w, uns));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
